stopwatch_core: RTL and testbench
=================================

// Module: stopwatch_core
// PURPOSE
//   Stopwatch time base downstream of the 100 Hz enable generator: counts en_100hz ticks
//   into BCD centiseconds/seconds/minutes under start/stop and lap/clear control.
//   Drives the registered BCD display bus consumed by the 7-segment scan stage.
//   Button inputs arrive debounced and edge-detected, one clk wide.
// PARAMETERS
//   MIN_MAX   59   highest minute value before wrap; legal 1..99 (BCD)
// PORTS
//   clk         in   1  system clock (50 MHz)
//   rst         in   1  synchronous, active-high reset
//   en_100hz    in   1  one-clk tick, 100 Hz
//   start_stop  in   1  one-clk pulse: start / pause / resume
//   lap_clr     in   1  one-clk pulse: lap freeze / release, or clear when paused
//   disp_cs     out  8  BCD {tens,ones} centiseconds 00..99
//   disp_sec    out  8  BCD {tens,ones} seconds 00..59
//   disp_min    out  8  BCD {tens,ones} minutes 00..MIN_MAX
//   running     out  1  1 in RUN or LAP
//   lap_active  out  1  1 in LAP (display frozen)
//   ovf         out  1  sticky: count wrapped past MIN_MAX:59.99
// BEHAVIOUR
//   Reset (rst=1 at posedge): state IDLE, counter 00:00.00, all outputs 0; overrides all inputs.
//   FSM states: IDLE, RUN, LAP, PAUSE. start_stop has priority over lap_clr in the same clk;
//   when both are high, lap_clr is ignored.
//     IDLE : start_stop -> RUN; lap_clr ignored.
//     RUN  : start_stop -> PAUSE; lap_clr -> LAP.
//     LAP  : lap_clr -> RUN (display live again); start_stop -> PAUSE (display live again).
//     PAUSE: start_stop -> RUN (resume, no clear); lap_clr -> IDLE, counter and ovf cleared.
//   Counting: the counter increments by 1 cs when the registered state is RUN or LAP and
//   en_100hz=1. A tick in the same clk as the transition into RUN is not counted.
//   A tick in the same clk as RUN->PAUSE is counted.
//   Counter is six BCD digits. ones 9->0 carries to tens; cs 99->00 carries to sec;
//   sec 59->00 carries to min. All carries resolve in the same clk.
//   Wrap: MIN_MAX:59.99 + tick -> 00:00.00 and ovf<=1. Counting continues.
//   ovf clears only on rst or on PAUSE->IDLE.
//   Display: disp_* <= counter every clk when not in LAP, giving 1 clk latency from the counter.
//   On entry to LAP, disp_* hold the value registered in the clk lap_clr was sampled (the
//   pre-increment count) until LAP is left. The counter keeps running underneath.
//   running and lap_active are registered decodes of the next state; they change in the same
//   clk as the state register.
//   No combinational path from any input to any output.
// TESTING
//   T1 rst; start_stop; 100 ticks -> disp 00:01.00, running=1, ovf=0.
//   T2 MIN_MAX=1, tick every clk: 12000 ticks -> counter 00:00.00, ovf=1.
//      Tick 11999 -> disp 01:59.99, ovf=0.
//   T3 250 ticks; lap_clr -> disp 00:02.50, lap_active=1. 100 more ticks -> disp unchanged.
//      lap_clr -> disp 00:03.50 one clk later.
//   T4 pause at 00:00.42; 50 ticks -> disp stays 00:00.42. start_stop; 8 ticks -> 00:00.50.
//      start_stop; lap_clr -> 00:00.00, IDLE, ovf=0.
//   T5 simultaneous start_stop+lap_clr in RUN -> PAUSE, lap_active=0.
//      Tick coincident with start_stop in IDLE -> count stays 00:00.00.
//   T6 rst asserted mid-LAP at 00:07.31 -> next clk all outputs 0, state IDLE;
//      ticks ignored until start_stop.

Source files
------------

// File: rtl/stopwatch_core.sv
// Stopwatch time base: BCD mm:ss.cc counter with run/lap/pause control.
// Display, running and lap flags are all registered; no input reaches an output combinationally.
module stopwatch_core #(
    parameter int MIN_MAX = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_100hz,
    input  logic       start_stop,
    input  logic       lap_clr,
    output logic [7:0] disp_cs,
    output logic [7:0] disp_sec,
    output logic [7:0] disp_min,
    output logic       running,
    output logic       lap_active,
    output logic       ovf
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        LAP,
        PAUSE
    } state_t;

    localparam logic [7:0] MIN_BCD = {4'(MIN_MAX / 10), 4'(MIN_MAX % 10)};

    state_t     state_q, state_d;
    logic [7:0] cs_q, cs_d;
    logic [7:0] sec_q, sec_d;
    logic [7:0] min_q, min_d;
    logic [7:0] dcs_q, dcs_d;
    logic [7:0] dsec_q, dsec_d;
    logic [7:0] dmin_q, dmin_d;
    logic       ovf_q, ovf_d;
    logic       run_q, run_d;
    logic       lap_q, lap_d;
    logic       clr;
    logic [8:0] cs_inc, sec_inc, min_inc;

    // {carry, next value}: wraps to 00 with carry once max is reached
    function automatic logic [8:0] bcd_inc(input logic [7:0] v,
                                           input logic [7:0] max);
        if (v == max) return 9'h100;
        if (v[3:0] == 4'd9) return {1'b0, v[7:4] + 4'd1, 4'd0};
        return {1'b0, v + 8'd1};
    endfunction

    assign cs_inc  = bcd_inc(cs_q, 8'h99);
    assign sec_inc = bcd_inc(sec_q, 8'h59);
    assign min_inc = bcd_inc(min_q, MIN_BCD);

    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_stop) state_d = RUN;
            end
            RUN: begin
                if (start_stop)   state_d = PAUSE;
                else if (lap_clr) state_d = LAP;
            end
            LAP: begin
                if (start_stop)   state_d = PAUSE;
                else if (lap_clr) state_d = RUN;
            end
            PAUSE: begin
                if (start_stop) begin
                    state_d = RUN;
                end else if (lap_clr) begin
                    state_d = IDLE;
                    clr     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cs_d  = cs_q;
        sec_d = sec_q;
        min_d = min_q;
        ovf_d = ovf_q;
        if (clr) begin
            cs_d  = 8'h00;
            sec_d = 8'h00;
            min_d = 8'h00;
            ovf_d = 1'b0;
        end else if ((state_q == RUN || state_q == LAP) && en_100hz) begin
            cs_d = cs_inc[7:0];
            if (cs_inc[8]) begin
                sec_d = sec_inc[7:0];
                if (sec_inc[8]) begin
                    min_d = min_inc[7:0];
                    if (min_inc[8]) ovf_d = 1'b1;
                end
            end
        end
    end

    // Display freezes on the pre-increment count while the registered state is LAP
    always_comb begin
        dcs_d  = dcs_q;
        dsec_d = dsec_q;
        dmin_d = dmin_q;
        if (state_q != LAP) begin
            dcs_d  = cs_q;
            dsec_d = sec_q;
            dmin_d = min_q;
        end
        run_d = (state_d == RUN) || (state_d == LAP);
        lap_d = (state_d == LAP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cs_q    <= 8'h00;
            sec_q   <= 8'h00;
            min_q   <= 8'h00;
            dcs_q   <= 8'h00;
            dsec_q  <= 8'h00;
            dmin_q  <= 8'h00;
            ovf_q   <= 1'b0;
            run_q   <= 1'b0;
            lap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cs_q    <= cs_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            dcs_q   <= dcs_d;
            dsec_q  <= dsec_d;
            dmin_q  <= dmin_d;
            ovf_q   <= ovf_d;
            run_q   <= run_d;
            lap_q   <= lap_d;
        end
    end

    assign disp_cs    = dcs_q;
    assign disp_sec   = dsec_q;
    assign disp_min   = dmin_q;
    assign running    = run_q;
    assign lap_active = lap_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: total-centisecond model compared every cycle,
// plus hand-computed literal checks for the directed scenarios.
module tb_stopwatch_core;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic       rst = 1'b1;
    logic       en_100hz = 1'b0;
    logic       start_stop = 1'b0;
    logic       lap_clr = 1'b0;
    logic [7:0] disp_cs, disp_sec, disp_min;
    logic       running, lap_active, ovf;
    logic [23:0] disp;

    assign disp = {disp_min, disp_sec, disp_cs};

    stopwatch_core #(.MIN_MAX(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .en_100hz  (en_100hz),
        .start_stop(start_stop),
        .lap_clr   (lap_clr),
        .disp_cs   (disp_cs),
        .disp_sec  (disp_sec),
        .disp_min  (disp_min),
        .running   (running),
        .lap_active(lap_active),
        .ovf       (ovf)
    );

    localparam int MODV = 2 * 6000;
    localparam int S_IDLE = 0, S_RUN = 1, S_LAP = 2, S_PAUSE = 3;

    int vectors = 0;
    int miscompares = 0;
    bit chk = 1'b0;

    int m_state = S_IDLE;
    int m_cnt = 0;
    int m_disp = 0;
    bit m_ovf = 1'b0;

    function automatic logic [7:0] bcd2(int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [23:0] exp_disp();
        return {bcd2(m_disp / 6000), bcd2((m_disp / 100) % 60),
                bcd2(m_disp % 100)};
    endfunction

    // Model: count held as total centiseconds modulo the wrap period
    task automatic model_step();
        int ns;
        bit clr;
        ns  = m_state;
        clr = 1'b0;
        if (rst) begin
            m_state = S_IDLE;
            m_cnt   = 0;
            m_disp  = 0;
            m_ovf   = 1'b0;
            return;
        end
        if (m_state == S_IDLE && start_stop) ns = S_RUN;
        if (m_state == S_RUN)
            ns = start_stop ? S_PAUSE : (lap_clr ? S_LAP : S_RUN);
        if (m_state == S_LAP)
            ns = start_stop ? S_PAUSE : (lap_clr ? S_RUN : S_LAP);
        if (m_state == S_PAUSE) begin
            if (start_stop) ns = S_RUN;
            else if (lap_clr) begin
                ns  = S_IDLE;
                clr = 1'b1;
            end
        end
        if (m_state != S_LAP) m_disp = m_cnt;
        if (clr) begin
            m_cnt = 0;
            m_ovf = 1'b0;
        end else if ((m_state == S_RUN || m_state == S_LAP) && en_100hz) begin
            m_cnt = m_cnt + 1;
            if (m_cnt == MODV) begin
                m_cnt = 0;
                m_ovf = 1'b1;
            end
        end
        m_state = ns;
    endtask

    task automatic cyc(input logic r, input logic s,
                       input logic l, input logic e);
        rst        = r;
        start_stop = s;
        lap_clr    = l;
        en_100hz   = e;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic lit(input string nm, input logic [23:0] act,
                       input logic [23:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    initial begin
        logic [23:0] ed;
        bit er, el;
        forever begin
            @(negedge clk);
            if (chk) begin
                ed = exp_disp();
                er = (m_state == S_RUN) || (m_state == S_LAP);
                el = (m_state == S_LAP);
                vectors++;
                if (disp !== ed || running !== er ||
                    lap_active !== el || ovf !== m_ovf) begin
                    miscompares++;
                    $display("FAIL cycle @%0t: got %h r%b l%b o%b, expected %h r%b l%b o%b",
                             $time, disp, running, lap_active, ovf,
                             ed, er, el, m_ovf);
                end
            end
        end
    end

    initial begin
        // reset overrides active inputs
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        chk = 1'b1;
        lit("reset_disp", disp, 24'h000000);
        lit("reset_flags", {21'd0, running, lap_active, ovf}, 24'h0);

        // T1
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(100);
        idle(1);
        lit("t1_disp", disp, 24'h000100);
        lit("t1_flags", {21'd0, running, lap_active, ovf}, 24'h4);

        // T3
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(250);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        lit("t3_lap_disp", disp, 24'h000250);
        lit("t3_lap_flag", {23'd0, lap_active}, 24'h1);
        ticks(100);
        lit("t3_frozen", disp, 24'h000250);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        lit("t3_release_hold", disp, 24'h000250);
        idle(1);
        lit("t3_live", disp, 24'h000350);

        // T2
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(11999);
        idle(1);
        lit("t2_last", disp, 24'h015999);
        lit("t2_no_ovf", {23'd0, ovf}, 24'h0);
        ticks(1);
        lit("t2_ovf", {23'd0, ovf}, 24'h1);
        idle(1);
        lit("t2_wrap", disp, 24'h000000);

        // T4 (continues from the wrap, ovf still set)
        ticks(42);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);
        lit("t4_pause", disp, 24'h000042);
        lit("t4_pause_run", {23'd0, running}, 24'h0);
        ticks(50);
        lit("t4_paused", disp, 24'h000042);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(8);
        idle(1);
        lit("t4_resume", disp, 24'h000050);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        lit("t4_ovf_kept", {23'd0, ovf}, 24'h1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        idle(1);
        lit("t4_clear", disp, 24'h000000);
        lit("t4_clear_flags", {21'd0, running, lap_active, ovf}, 24'h0);

        // T5
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        idle(1);
        lit("t5_start_tick", disp, 24'h000000);
        ticks(3);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        lit("t5_both", {22'd0, running, lap_active}, 24'h0);
        idle(1);
        lit("t5_pause_tick", disp, 24'h000004);

        // T6
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(731);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        ticks(10);
        lit("t6_lap", disp, 24'h000731);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        lit("t6_rst_disp", disp, 24'h000000);
        lit("t6_rst_flags", {21'd0, running, lap_active, ovf}, 24'h0);
        ticks(20);
        lit("t6_ignored", disp, 24'h000000);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(5);
        idle(1);
        lit("t6_restart", disp, 24'h000005);

        chk = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
